// File: rtl/ddr_clk_gen.sv
// ddr_clk_gen
//   Clock generator for the LPDDR controller. Everything runs on the rising edge
//   of SYS_CLK_100M. The block derives three clocks from it, all driven from
//   registers:
//     - WR_CLK, the 2x write clock (SYS/WR_DIV);
//     - DDR_CLK, the 1x memory clock (WR_CLK/2);
//     - the complementary CLK_P/CLK_N pair sent to the DRAM.
//   After reset it counts LOCK_CYCLES edges before it raises LOCKED. CLK_STOP
//   parks all clocks low at the next DDR_CLK period boundary.
//
// Ports
//   SYS_CLK_100M  in   system clock
//   RESET_N       in   asynchronous active-low reset
//   CLK_STOP      in   park request (honoured only at a period boundary)
//   WR_CLK        out  write clock, 50% duty
//   DDR_CLK       out  memory clock, 50% duty, rises only with WR_CLK
//   CLK_P/CLK_N   out  DRAM clock pair, exact complements of DDR_CLK
//   LOCKED        out  clocks valid, sticky until reset
//   STOPPED       out  clocks parked by CLK_STOP
module ddr_clk_gen #(
  parameter int WR_DIV      = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic SYS_CLK_100M,
  input  logic RESET_N,
  input  logic CLK_STOP,
  output logic WR_CLK,
  output logic DDR_CLK,
  output logic CLK_P,
  output logic CLK_N,
  output logic LOCKED,
  output logic STOPPED
);

  localparam int H  = WR_DIV / 2;
  localparam int DW = $clog2(H) + 1;
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [DW-1:0] H_M1    = DW'(H - 1);
  localparam logic [LW-1:0] LOCK_M1 = LW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic            wr_q, wr_d;
  logic            ddr_q, ddr_d;

  always_ff @(posedge SYS_CLK_100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_LOCKING;
      lock_cnt_q <= '0;
      div_cnt_q  <= '0;
      wr_q       <= 1'b0;
      ddr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      div_cnt_q  <= div_cnt_d;
      wr_q       <= wr_d;
      ddr_q      <= ddr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    div_cnt_d  = div_cnt_q;
    wr_d       = wr_q;
    ddr_d      = ddr_q;

    case (state_q)
      ST_LOCKING: begin
        // lock_cnt only advances here, so it stays saturated once LOCKED is set.
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (lock_cnt_q == LOCK_M1) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (div_cnt_q == H_M1) begin
          div_cnt_d = '0;
          // Both clocks low and about to rise: this is the only point where a
          // stop may take effect, so a DDR_CLK period is never cut short.
          if (!wr_q && !ddr_q && CLK_STOP) begin
            state_d = ST_STOPPED;
          end else begin
            wr_d = ~wr_q;
            // DDR_CLK toggles only on a WR_CLK rise, which keeps its edges aligned.
            if (!wr_q) begin
              ddr_d = ~ddr_q;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_STOPPED: begin
        // Restart with a rising edge on both clocks right away, at the start of
        // a new period.
        if (!CLK_STOP) begin
          state_d   = ST_RUN;
          wr_d      = 1'b1;
          ddr_d     = 1'b1;
          div_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_LOCKING;
      end
    endcase
  end

  assign WR_CLK  = wr_q;
  assign DDR_CLK = ddr_q;
  // Both DRAM pins come from the same register, so they are always exact complements.
  assign CLK_P   = ddr_q;
  assign CLK_N   = ~ddr_q;
  assign LOCKED  = (state_q != ST_LOCKING);
  assign STOPPED = (state_q == ST_STOPPED);

endmodule

// File: tb/tb_ddr_clk_gen.sv
// Bench for ddr_clk_gen. It drives two instances from one clock:
//   - A uses WR_DIV=2;
//   - B uses WR_DIV=6.
// Both instances use LOCK_CYCLES=16.
// The reference model describes behaviour as a position within the DDR_CLK
// period (period = 4*H system cycles) and derives the clock levels from that
// position.
module tb_ddr_clk_gen;

  localparam int HA = 1;
  localparam int HB = 3;
  localparam int LC = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic stop_a, stop_b;
  logic a_wr, a_ddr, a_p, a_n, a_lk, a_st;
  logic b_wr, b_ddr, b_p, b_n, b_lk, b_st;

  int checks = 0;
  int errors = 0;
  int b_rises = 0;

  always #5 clk = ~clk;

  ddr_clk_gen #(.WR_DIV(2), .LOCK_CYCLES(LC)) dut_a (
    .SYS_CLK_100M(clk), .RESET_N(rst_n), .CLK_STOP(stop_a),
    .WR_CLK(a_wr), .DDR_CLK(a_ddr), .CLK_P(a_p), .CLK_N(a_n),
    .LOCKED(a_lk), .STOPPED(a_st)
  );

  ddr_clk_gen #(.WR_DIV(6), .LOCK_CYCLES(LC)) dut_b (
    .SYS_CLK_100M(clk), .RESET_N(rst_n), .CLK_STOP(stop_b),
    .WR_CLK(b_wr), .DDR_CLK(b_ddr), .CLK_P(b_p), .CLK_N(b_n),
    .LOCKED(b_lk), .STOPPED(b_st)
  );

  wire [5:0] out_a = {a_wr, a_ddr, a_p, a_n, a_lk, a_st};
  wire [5:0] out_b = {b_wr, b_ddr, b_p, b_n, b_lk, b_st};

  always @(posedge b_wr) b_rises++;

  // Reference model: mode plus a position within the DDR period.
  localparam int M_LOCK = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;
  localparam int M_STOP = 3;

  typedef struct {
    int mode;
    int cnt;
    int pos;
  } model_t;

  function automatic model_t m_reset();
    model_t m;
    m.mode = M_LOCK;
    m.cnt  = 0;
    m.pos  = 0;
    return m;
  endfunction

  function automatic model_t m_step(model_t m, logic stop, int h);
    model_t r = m;
    case (m.mode)
      M_LOCK: begin
        r.cnt = m.cnt + 1;
        if (r.cnt == LC) begin
          r.mode = M_WAIT;
          r.cnt  = h;
        end
      end
      M_WAIT: begin
        r.cnt = m.cnt - 1;
        if (r.cnt == 0) begin
          if (stop) r.mode = M_STOP;
          else begin
            r.mode = M_RUN;
            r.pos  = 0;
          end
        end
      end
      M_RUN: begin
        r.pos = m.pos + 1;
        if (r.pos == 4 * h) begin
          if (stop) r.mode = M_STOP;
          else r.pos = 0;
        end
      end
      default: begin
        if (!stop) begin
          r.mode = M_RUN;
          r.pos  = 0;
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [5:0] m_out(model_t m, int h);
    logic wr, ddr;
    wr  = (m.mode == M_RUN) && (((m.pos / h) % 2) == 0);
    ddr = (m.mode == M_RUN) && (m.pos < 2 * h);
    return {wr, ddr, ddr, ~ddr, (m.mode != M_LOCK), (m.mode == M_STOP)};
  endfunction

  model_t ma = m_reset();
  model_t mb = m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = m_reset();
      mb = m_reset();
    end else begin
      ma = m_step(ma, stop_a, HA);
      mb = m_step(mb, stop_b, HB);
    end
  end

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b (wr,ddr,p,n,locked,stopped) t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("model_a", out_a, m_out(ma, HA));
    chk("model_b", out_b, m_out(mb, HB));
  end

  typedef struct {
    logic       rst_n;
    logic       stop;
    int         edges;
    logic [5:0] exp;
    string      name;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, int e, logic [5:0] x, string n);
    vec_t v;
    v.rst_n = r;
    v.stop  = s;
    v.edges = e;
    v.exp   = x;
    v.name  = n;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1'b0, 1'b0,  2, 6'b000100, "reset_values");
    tbl[1]  = mk(1'b1, 1'b0, 15, 6'b000100, "prelock_15");
    tbl[2]  = mk(1'b1, 1'b0,  1, 6'b000110, "lock_edge16");
    tbl[3]  = mk(1'b1, 1'b0,  1, 6'b111010, "first_rise17");
    tbl[4]  = mk(1'b1, 1'b0,  1, 6'b011010, "wr_fall");
    tbl[5]  = mk(1'b1, 1'b0,  1, 6'b100110, "wr_rise_ddr_low");
    tbl[6]  = mk(1'b1, 1'b0,  1, 6'b000110, "both_low");
    tbl[7]  = mk(1'b1, 1'b0,  1, 6'b111010, "second_period");
    tbl[8]  = mk(1'b1, 1'b1,  1, 6'b011010, "stop_while_high");
    tbl[9]  = mk(1'b1, 1'b1,  2, 6'b000110, "period_completes");
    tbl[10] = mk(1'b1, 1'b1,  1, 6'b000111, "stopped_at_boundary");
    tbl[11] = mk(1'b1, 1'b1,  3, 6'b000111, "stop_hold");
    tbl[12] = mk(1'b1, 1'b0,  1, 6'b111010, "restart_next_edge");
    tbl[13] = mk(1'b1, 1'b0,  1, 6'b011010, "restart_cadence");
    tbl[14] = mk(1'b1, 1'b0,  6, 6'b000110, "run_after_restart");

    rst_n  = 1'b0;
    stop_a = 1'b0;
    stop_b = 1'b1;  // B holds CLK_STOP from reset onward

    // Table-driven sequence on instance A
    for (int i = 0; i < 15; i++) begin
      rst_n  = tbl[i].rst_n;
      stop_a = tbl[i].stop;
      repeat (tbl[i].edges) @(posedge clk);
      @(negedge clk);
      chk(tbl[i].name, out_a, tbl[i].exp);
    end

    // B had CLK_STOP high from reset: locked and parked, never pulsed
    chk("b_stop_from_reset", out_b, 6'b000111);
    chk("b_no_pulse", {5'd0, (b_rises == 0)}, 6'b000001);

    // B release: both clocks rise on the next edge, then WR_CLK stays high for 3 cycles
    stop_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b_restart", out_b, 6'b111010);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_wr_high3", out_b, 6'b111010);
    @(posedge clk);
    @(negedge clk);
    chk("b_wr_fall", out_b, 6'b011010);

    // Randomised CLK_STOP activity; the per-cycle monitor compares both instances against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) stop_a = ~stop_a;
      if ($urandom_range(0, 9) == 0) stop_b = ~stop_b;
      @(negedge clk);
    end

    // Asynchronous reset mid-run, between edges
    stop_a = 1'b0;
    stop_b = 1'b0;
    repeat (30) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", out_a, 6'b000100);
    chk("async_reset_b", out_b, 6'b000100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("relock_not_yet", out_a, 6'b000100);
    @(posedge clk);
    @(negedge clk);
    chk("relock_16", out_a, 6'b000110);
    @(posedge clk);
    @(negedge clk);
    chk("relock_first_rise", out_a, 6'b111010);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
